// File: rtl/access_control_if.sv
// Keypad/password bus between the process controller and the access-control block.
interface access_control_if;
  logic        enable;
  logic [3:0]  digit_in;
  logic        enter;
  logic        pwd_load;
  logic [15:0] pwd_new;
  logic        access_granted;
  logic        access_denied;
  logic        locked;
  logic [2:0]  digit_count;
  logic [1:0]  tries;

  modport slave (
    input  enable, digit_in, enter, pwd_load, pwd_new,
    output access_granted, access_denied, locked, digit_count, tries
  );

  modport master (
    output enable, digit_in, enter, pwd_load, pwd_new,
    input  access_granted, access_denied, locked, digit_count, tries
  );
endinterface

// File: rtl/access_control.sv
// Four-digit BCD password check with retry counting and timed lockout.
// All outputs are registered; result pulses appear two edges after the 4th digit.
module access_control #(
  parameter logic [15:0] DEFAULT_PWD = 16'h1234,
  parameter int          MAX_TRIES   = 3,
  parameter int          LOCK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  access_control_if.slave  ac
);

  localparam int             LCW       = $clog2(LOCK_CYCLES);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [1:0]     TRY_MAX   = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_GRANT, S_DENY, S_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      buf_q, buf_d;
  logic [15:0]      pwd_q, pwd_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       tries_q, tries_d;
  logic [LCW-1:0]   lcnt_q, lcnt_d;
  logic             gr_q, gr_d, dn_q, dn_d, lk_q, lk_d;
  logic [1:0]       tries_inc;

  function automatic logic all_bcd(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  assign tries_inc = tries_q + 2'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pwd_d   = pwd_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    lcnt_d  = lcnt_q;
    gr_d    = 1'b0;
    dn_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ac.pwd_load && all_bcd(ac.pwd_new)) pwd_d = ac.pwd_new;
        if (ac.enable) begin
          state_d = S_ENTRY;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      S_ENTRY: begin
        // Dropping enable abandons the attempt even if a digit arrives together.
        if (!ac.enable) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (ac.enter && ac.digit_in <= 4'd9) begin
          buf_d = {buf_q[11:0], ac.digit_in};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (buf_q == pwd_q) begin
          state_d = S_GRANT;
        end else begin
          tries_d = tries_inc;
          state_d = (tries_inc == TRY_MAX) ? S_LOCKED : S_DENY;
        end
      end
      S_GRANT: begin
        gr_d    = 1'b1;
        tries_d = '0;
        cnt_d   = '0;
        buf_d   = '0;
        state_d = S_IDLE;
      end
      S_DENY: begin
        dn_d    = 1'b1;
        buf_d   = '0;
        cnt_d   = '0;
        state_d = ac.enable ? S_ENTRY : S_IDLE;
      end
      S_LOCKED: begin
        buf_d = '0;
        cnt_d = '0;
        if (lcnt_q == LOCK_LAST) begin
          lcnt_d  = '0;
          tries_d = '0;
          state_d = S_IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    lk_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      pwd_q   <= DEFAULT_PWD;
      cnt_q   <= '0;
      tries_q <= '0;
      lcnt_q  <= '0;
      gr_q    <= 1'b0;
      dn_q    <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pwd_q   <= pwd_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      lcnt_q  <= lcnt_d;
      gr_q    <= gr_d;
      dn_q    <= dn_d;
      lk_q    <= lk_d;
    end
  end

  assign ac.access_granted = gr_q;
  assign ac.access_denied  = dn_q;
  assign ac.locked         = lk_q;
  assign ac.digit_count    = cnt_q;
  assign ac.tries          = tries_q;

endmodule

// File: tb/tb_access_control.sv
// Random keypad traffic against a timeline model of attempts, results and lockouts.
module tb_access_control;
  localparam int L  = 1000;
  localparam int MT = 3;
  localparam int K_OK = 0, K_BAD = 1, K_LOCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  access_control_if ac();

  access_control #(.DEFAULT_PWD(16'h1234), .MAX_TRIES(MT), .LOCK_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .ac(ac)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: an attempt completed at edge t0 yields its effects at fixed offsets from t0.
  logic [15:0] m_pwd;
  int m_tries, m_dcnt, m_kind, m_t0, now;
  bit m_in_entry, m_busy, m_gr, m_dn, m_lk;
  int digits[$];
  int tgt[4];

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++)
      if (((v >> (4 * i)) & 16'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pwd = 16'h1234; m_tries = 0; m_dcnt = 0; m_in_entry = 0;
    m_busy = 0; m_gr = 0; m_dn = 0; m_lk = 0;
    digits.delete();
  endtask

  task automatic model_step(input bit en, input bit ent, input logic [3:0] d,
                            input bit ld, input logic [15:0] nw);
    int k, val;
    m_gr = 0; m_dn = 0;
    if (m_busy) begin
      k = now - m_t0;
      if (k == 1 && m_kind != K_OK) m_tries++;
      if (k == 1 && m_kind == K_LOCK) m_lk = 1;
      if (k == 2) begin
        m_dcnt = 0;
        digits.delete();
        if (m_kind == K_OK) begin m_gr = 1; m_tries = 0; m_in_entry = 0; m_busy = 0; end
        if (m_kind == K_BAD) begin m_dn = 1; m_in_entry = en; m_busy = 0; end
      end
      if (m_kind == K_LOCK && k == L + 1) begin
        m_lk = 0; m_tries = 0; m_in_entry = 0; m_busy = 0;
      end
    end else if (!m_in_entry) begin
      if (ld && bcd_ok(nw)) m_pwd = nw;
      if (en) begin m_in_entry = 1; digits.delete(); m_dcnt = 0; end
    end else if (!en) begin
      m_in_entry = 0; digits.delete(); m_dcnt = 0;
    end else if (ent && d <= 9) begin
      digits.push_back(int'(d));
      m_dcnt = digits.size();
      if (digits.size() == 4) begin
        val = digits[0] * 4096 + digits[1] * 256 + digits[2] * 16 + digits[3];
        m_t0 = now; m_busy = 1;
        if (val == int'(m_pwd))      m_kind = K_OK;
        else if (m_tries + 1 == MT)  m_kind = K_LOCK;
        else                         m_kind = K_BAD;
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "granted"}, 16'(ac.access_granted), 16'(m_gr));
    check({pfx, "denied"},  16'(ac.access_denied),  16'(m_dn));
    check({pfx, "locked"},  16'(ac.locked),         16'(m_lk));
    check({pfx, "digit_count"}, 16'(ac.digit_count), 16'(m_dcnt));
    check({pfx, "tries"},   16'(ac.tries),          16'(m_tries));
  endtask

  // Asserted and checked between edges: outputs must clear with no clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async_");
    @(posedge clk);
    #1 check_outputs("rst_held_");
    #2 rst = 1'b0;
  endtask

  task automatic drive_inputs(input int pct);
    if (m_dcnt == 0)
      for (int i = 0; i < 4; i++)
        tgt[i] = ($urandom_range(0, 99) < pct) ? int'((m_pwd >> (12 - 4 * i)) & 16'hF)
                                                : int'($urandom_range(0, 9));
    ac.enable   = ($urandom_range(0, 59) != 0);
    ac.enter    = 1'($urandom_range(0, 1));
    ac.digit_in = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                               : 4'(tgt[(m_dcnt < 4) ? m_dcnt : 0]);
    ac.pwd_load = ($urandom_range(0, 39) == 0);
    ac.pwd_new  = $urandom_range(0, 1) ?
                  16'($urandom_range(0, 9) * 4096 + $urandom_range(0, 9) * 256 +
                      $urandom_range(0, 9) * 16 + $urandom_range(0, 9)) :
                  16'($urandom);
  endtask

  bit did_entry_rst = 0, did_lock_rst = 0;

  task automatic run_phase(input int pct, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive_inputs(pct);
      @(posedge clk);
      now++;
      model_step(ac.enable, ac.enter, ac.digit_in, ac.pwd_load, ac.pwd_new);
      #1 check_outputs("");
      if (!did_entry_rst && m_in_entry && !m_busy && m_dcnt == 2) begin
        did_entry_rst = 1; async_reset();
      end else if (!did_lock_rst && m_busy && m_kind == K_LOCK && now - m_t0 == 500) begin
        did_lock_rst = 1; async_reset();
      end else if ($urandom_range(0, 2999) == 0) begin
        async_reset();
      end
    end
  endtask

  initial begin
    ac.enable = 1'b0; ac.enter = 1'b0; ac.digit_in = 4'd0;
    ac.pwd_load = 1'b0; ac.pwd_new = 16'd0;
    model_reset();
    now = 0;
    #3 check_outputs("reset_");
    @(posedge clk);
    #1 check_outputs("reset_held_");
    #2 rst = 1'b0;
    run_phase(70, 8000);
    run_phase(10, 8000);
    run_phase(50, 8000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
